adc_promediador_muestras: RTL and testbench
===========================================

// Module: adc_promediador_muestras
// PURPOSE
//  Downstream stage of the serial ADC receiver. Captures each finished sample
//  (dato_sin_basura + listo) into a circular buffer of 2**LOG_DEPTH entries and
//  outputs a running moving average with a one-cycle valid strobe.
//  Runs in the receiver's sample-clock domain (the divided 44 kHz clk).
//  Feeds the display / DAC stages.
// PARAMETERS
//  WIDTH      4  bits per ADC sample (matches receiver width)
//  LOG_DEPTH  3  log2 of averaging window; depth D = 2**LOG_DEPTH, 1..6 supported
// PORTS
//  clk        in   1                sample clock, same clock as the ADC receiver
//  reset      in   1                synchronous, active-high reset
//  dato       in   WIDTH            sample from receiver (dato_sin_basura)
//  listo      in   1                receiver done flag; level, may stay high many cycles
//  limpiar    in   1                synchronous clear of window; same effect as reset
//  promedio   out  WIDTH            moving average = sum >> LOG_DEPTH (truncating)
//  valido     out  1                1-cycle pulse when promedio updated with full window
//  lleno      out  1                high once D samples captured since reset/limpiar
//  pico       out  WIDTH            max sample since reset/limpiar (see CONFIGURATION)
// BEHAVIOUR
//  - Reset/limpiar: promedio=0, valido=0, lleno=0, pico=0, all buffer entries=0,
//    sum=0, wr_ptr=0, count=0, state=LLENANDO. One clock cycle to take effect.
//  - Capture event: clock edge where listo=1 and listo_q=0 (listo_q = listo
//    registered, cleared by reset). Exactly one capture per listo rising edge.
//  - On capture edge: buf[wr_ptr]<=dato; sum<=sum+dato-buf[wr_ptr] (old value);
//    wr_ptr<=wr_ptr+1 (wraps D-1 -> 0); count<=count+1 (saturates at D).
//  - sum width WIDTH+LOG_DEPTH; never overflows; never negative (old entry
//    is part of sum).
//  - Edge after capture: promedio<=sum>>LOG_DEPTH (updated every capture, also
//    while filling). valido<=1 only if state=PROMEDIANDO; else 0.
//  - Latency: listo rise sampled at edge N -> promedio/valido visible after edge N+1.
//  - FSM: LLENANDO -> PROMEDIANDO at capture edge writing the D-th sample
//    (count D-1 -> D). PROMEDIANDO stays until reset/limpiar. lleno = (state==PROMEDIANDO).
//  - First valido pulse therefore follows the D-th captured sample.
//  - Priority: reset > limpiar > capture. A capture coincident with limpiar is
//    discarded; listo_q still updates, so a held listo does not re-trigger after clear.
//  - Reset mid-window: all partial data lost; next D samples refill.
//  - dato is sampled only at the capture edge; changes at other cycles ignored.
// CONFIGURATION
//  ADC_PEAK_HOLD_EN defined: pico register updated at each capture edge to
//    max(pico, dato); cleared by reset/limpiar; visible one edge after capture.
//  Not defined: no peak logic synthesised; pico tied to 0.
// TESTING  (WIDTH=4, LOG_DEPTH=2, D=4 unless noted)
//  1 reset 3 cycles with listo toggling -> promedio=0, valido=0, lleno=0, pico=0.
//  2 capture 4,8,12,0 -> valido low for first 3; after 4th: lleno=1, promedio=6,
//    valido=1 for exactly 1 cycle, one edge after capture.
//  3 continue with 15 -> sum 24-4+15=35, promedio=8; then 15,15,15 -> promedio=15
//    (pointer wrap verified).
//  4 listo held high 6 cycles with dato=9 -> exactly one capture, one valido pulse.
//  5 limpiar asserted on same edge as a listo rise -> sample discarded, count=0,
//    lleno=0; next 4 captures of 2 -> promedio=2, first valido after 4th.
//  6 ADC_PEAK_HOLD_EN: capture 3,15,2 -> pico=15, limpiar -> pico=0;
//    without macro pico stays 0 throughout.

Source files
------------

// File: rtl/adc_promediador_muestras.sv
// adc_promediador_muestras: moving average over the last 2**LOG_DEPTH ADC samples.
// Each rising edge of listo captures one sample into a circular buffer; the running
// sum is kept incrementally and promedio/valido follow one edge after the capture.
// Optional feature macro: ADC_PEAK_HOLD_EN (peak-hold register on pico; tied to 0 otherwise).
module adc_promediador_muestras #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dato,
    input  logic             listo,
    input  logic             limpiar,
    output logic [WIDTH-1:0] promedio,
    output logic             valido,
    output logic             lleno,
    output logic [WIDTH-1:0] pico
);

    localparam int unsigned DEPTH = 1 << LOG_DEPTH;
    localparam int unsigned SUM_W = WIDTH + LOG_DEPTH;
    localparam int unsigned CNT_W = LOG_DEPTH + 1;

    typedef enum logic {
        StLlenando,
        StPromediando
    } state_e;

    state_e                 state_q, state_d;
    logic                   listo_q;
    logic                   captura;
    logic                   borrar;
    logic                   cap_q;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [LOG_DEPTH-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [WIDTH-1:0]       promedio_q;
    logic                   valido_q;

    // Rising-edge detect on listo and the combined clear condition.
    always_comb begin
        captura = listo & ~listo_q;
        borrar  = reset | limpiar;
    end

    // listo history; only reset clears it so a listo held through limpiar cannot re-trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            listo_q <= 1'b0;
        end else begin
            listo_q <= listo;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (borrar) begin
            state_q <= StLlenando;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave the fill phase on the capture that writes the D-th sample.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLlenando: begin
                if (captura && (count_q == CNT_W'(DEPTH - 1))) begin
                    state_d = StPromediando;
                end
            end
            StPromediando: state_d = StPromediando;
            default:       state_d = StLlenando;
        endcase
    end

    // Incremental sum: the overwritten entry is already part of the sum, so the
    // result never goes negative; modular wrap of the intermediate is harmless.
    always_comb begin
        sum_d = sum_q + SUM_W'(dato) - SUM_W'(mem_q[wr_ptr_q]);
    end

    // Window buffer, sum, pointer, fill counter and the delayed average output.
    always_ff @(posedge clk) begin
        if (borrar) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            sum_q      <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            cap_q      <= 1'b0;
            promedio_q <= '0;
            valido_q   <= 1'b0;
        end else begin
            cap_q    <= captura;
            valido_q <= 1'b0;
            if (captura) begin
                mem_q[wr_ptr_q] <= dato;
                sum_q           <= sum_d;
                wr_ptr_q        <= wr_ptr_q + LOG_DEPTH'(1);
                if (count_q != CNT_W'(DEPTH)) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
            // One edge after a capture the sum reflects the new sample.
            if (cap_q) begin
                promedio_q <= sum_q[SUM_W-1:LOG_DEPTH];
                valido_q   <= (state_q == StPromediando);
            end
        end
    end

    // Output assignments.
    always_comb begin
        promedio = promedio_q;
        valido   = valido_q;
        lleno    = (state_q == StPromediando);
    end

`ifdef ADC_PEAK_HOLD_EN
    logic [WIDTH-1:0] pico_q;

    // Peak hold of captured samples since the last clear.
    always_ff @(posedge clk) begin
        if (borrar) begin
            pico_q <= '0;
        end else if (captura && (dato > pico_q)) begin
            pico_q <= dato;
        end
    end

    // Peak output.
    always_comb begin
        pico = pico_q;
    end
`else
    // Peak feature not built.
    always_comb begin
        pico = '0;
    end
`endif

endmodule

// File: tb/tb_adc_promediador_muestras.sv
// Scoreboard bench for adc_promediador_muestras (WIDTH=4, LOG_DEPTH=2).
module tb_adc_promediador_muestras;

    localparam int W = 4;
    localparam int L = 2;
`ifdef ADC_PEAK_HOLD_EN
    localparam bit PeakEn = 1'b1;
`else
    localparam bit PeakEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] dato;
    logic         listo;
    logic         limpiar;
    logic [W-1:0] promedio;
    logic         valido;
    logic         lleno;
    logic [W-1:0] pico;

    adc_promediador_muestras #(
        .WIDTH    (W),
        .LOG_DEPTH(L)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dato    (dato),
        .listo   (listo),
        .limpiar (limpiar),
        .promedio(promedio),
        .valido  (valido),
        .lleno   (lleno),
        .pico    (pico)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int prom;
        int at;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pk     = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valido pulse must match the next expected entry in value and cycle.
    always @(negedge clk) begin
        if (valido === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valido_unexpected: got valido=1 at cycle %0d, expected 0", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valido_cycle", cyc, e.at);
                chk("valido_promedio", int'(promedio), e.prom);
            end
        end
    end

    // One listo pulse; promedio/lleno/pico checked once the update is visible.
    task automatic capture(input int d, input int ep, input bit el, input bit ev);
        @(negedge clk);
        dato  = W'(d);
        listo = 1'b1;
        if (ev) q.push_back('{ep, cyc + 2});
        if (PeakEn && d > pk) pk = d;
        @(negedge clk);
        listo = 1'b0;
        dato  = '0;
        @(negedge clk);
        chk("promedio", int'(promedio), ep);
        chk("lleno", int'(lleno), int'(el));
        chk("pico", int'(pico), pk);
    endtask

    initial begin
        reset   = 1'b1;
        listo   = 1'b0;
        limpiar = 1'b0;
        dato    = 4'd7;

        // 1: reset with listo toggling
        repeat (3) begin
            @(negedge clk);
            listo = ~listo;
        end
        chk("rst_promedio", int'(promedio), 0);
        chk("rst_valido", int'(valido), 0);
        chk("rst_lleno", int'(lleno), 0);
        chk("rst_pico", int'(pico), 0);
        @(negedge clk);
        reset = 1'b0;
        listo = 1'b0;
        dato  = '0;

        // 2: fill window 4,8,12,0
        capture(4, 1, 1'b0, 1'b0);
        capture(8, 3, 1'b0, 1'b0);
        capture(12, 6, 1'b0, 1'b0);
        capture(0, 6, 1'b1, 1'b1);

        // 3: slide with 15s, pointer wraps
        capture(15, 8, 1'b1, 1'b1);
        capture(15, 10, 1'b1, 1'b1);
        capture(15, 11, 1'b1, 1'b1);
        capture(15, 15, 1'b1, 1'b1);

        // 4: listo held 6 cycles with 9; dato changes after capture are ignored
        @(negedge clk);
        dato  = 4'd9;
        listo = 1'b1;
        q.push_back('{13, cyc + 2});
        @(negedge clk);
        dato = 4'd0;
        repeat (5) @(negedge clk);
        listo = 1'b0;
        @(negedge clk);
        chk("held_promedio", int'(promedio), 13);
        chk("held_pico", int'(pico), pk);

        // 5: limpiar coincident with listo rise, listo kept high past the clear
        @(negedge clk);
        limpiar = 1'b1;
        listo   = 1'b1;
        dato    = 4'd5;
        @(negedge clk);
        limpiar = 1'b0;
        pk      = 0;
        repeat (2) @(negedge clk);
        listo = 1'b0;
        @(negedge clk);
        chk("clr_lleno", int'(lleno), 0);
        chk("clr_promedio", int'(promedio), 0);
        chk("clr_pico", int'(pico), 0);
        capture(2, 0, 1'b0, 1'b0);
        capture(2, 1, 1'b0, 1'b0);
        capture(2, 1, 1'b0, 1'b0);
        capture(2, 2, 1'b1, 1'b1);

        // 6: peak tracking then clear
        capture(3, 2, 1'b1, 1'b1);
        capture(15, 5, 1'b1, 1'b1);
        capture(2, 5, 1'b1, 1'b1);
        chk("peak_value", int'(pico), PeakEn ? 15 : 0);
        @(negedge clk);
        limpiar = 1'b1;
        @(negedge clk);
        limpiar = 1'b0;
        pk      = 0;
        chk("peak_clr_pico", int'(pico), 0);
        chk("peak_clr_lleno", int'(lleno), 0);
        chk("peak_clr_promedio", int'(promedio), 0);

        repeat (4) @(negedge clk);
        chk("pending_valido", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
